// File: rtl/snoop_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// snoop_bus_arbiter_pkg
//  Shared definitions for the snoop bus arbiter: memory I/O state codes,
//  default address/word widths, arbiter state encoding and a small helper
//  that classifies a cache message.
//  No ports (package).
// ---------------------------------------------------------------------------
package snoop_bus_arbiter_pkg;

   // Memory port request codes (rwToMem / mRw)
   localparam int                   IOSTATE_W = 2;
   localparam logic [IOSTATE_W-1:0] IO_IDEL   = 2'd0;
   localparam logic [IOSTATE_W-1:0] IO_RD     = 2'd1;
   localparam logic [IOSTATE_W-1:0] IO_WT     = 2'd2;

   // Default datapath widths
   localparam int ADDR_WIDTH = 16;
   localparam int WORD_WIDTH = 32;

   // Arbiter states (3-bit codes)
   typedef enum logic [2:0] {
      ARB_IDLE     = 3'd0,
      ARB_BCAST    = 3'd1,
      ARB_SNOOPWIN = 3'd2,
      ARB_WB       = 3'd3,
      ARB_OWNER    = 3'd4,
      ARB_DONE     = 3'd5
   } arb_state_t;

   // A pure invalidate carries no data and needs no memory phase.
   function automatic logic inv_only(input logic rm, input logic wm, input logic inv);
      return inv & ~rm & ~wm;
   endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// snoop_bus_arbiter_rr_picker
//  Combinational round-robin picker: returns the first set request bit at or
//  after ptr, wrapping past NUM_CACHES-1.
//  Ports:
//   req    in   NUM_CACHES  request vector
//   ptr    in   IDX_W       starting search position (< NUM_CACHES)
//   grant  out  NUM_CACHES  one-hot grant (0 when nothing requested)
//   idx    out  IDX_W       index of the granted request
//   valid  out  1           some request was found
// ---------------------------------------------------------------------------
module snoop_bus_arbiter_rr_picker #(
   parameter  int NUM_CACHES = 4,
   localparam int IDX_W      = $clog2(NUM_CACHES)
) (
   input  logic [NUM_CACHES-1:0] req,
   input  logic [IDX_W-1:0]      ptr,
   output logic [NUM_CACHES-1:0] grant,
   output logic [IDX_W-1:0]      idx,
   output logic                  valid
);

   always_comb begin
      int cand;
      cand  = 0;
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      for (int k = 0; k < NUM_CACHES; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_CACHES) cand = cand - NUM_CACHES;
         if (!valid && req[cand]) begin
            valid       = 1'b1;
            idx         = IDX_W'(cand);
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// ---------------------------------------------------------------------------
// snoop_bus_arbiter
//  Shares one snoop bus and one single-port memory among NUM_CACHES MSI
//  caches. One requester is chosen round-robin per transaction, its message
//  is broadcast to the other caches, a snooped MODIFIED owner gets memory
//  first for its write-back, then the requester gets memory.
//  Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqMsg/reqRm/reqWm/reqInv  per-cache message valid and type
//   reqAddr                    per-cache message address, cache i at [i*ADDR_W+:ADDR_W]
//   cRw/cAddr/cData            per-cache memory request port
//   allowRead                  per-cache permission to read from its cache
//   snpRm/snpWm/snpInv/snpAddr snoop broadcast (requester's own bit is 0)
//   cReadEn/cWriteDone         per-cache memory completion pulses
//   cDataOut                   read data broadcast to all caches
//   mRw/mAddr/mData            request to memory
//   mDataIn/mReadEn/mWriteDone response from memory
//   owner, busy, err           current owner, not-idle, sticky timeout flag
//  All outputs are registered.
// ---------------------------------------------------------------------------
module snoop_bus_arbiter
   import snoop_bus_arbiter_pkg::*;
#(
   parameter  int NUM_CACHES = 4,
   parameter  int ADDR_W     = ADDR_WIDTH,
   parameter  int WORD_W     = WORD_WIDTH,
   parameter  int TIMEOUT    = 64,
   localparam int IDX_W      = $clog2(NUM_CACHES),
   localparam int TMO_W      = $clog2(TIMEOUT + 1)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_CACHES-1:0]           reqMsg,
   input  logic [NUM_CACHES-1:0]           reqRm,
   input  logic [NUM_CACHES-1:0]           reqWm,
   input  logic [NUM_CACHES-1:0]           reqInv,
   input  logic [NUM_CACHES*ADDR_W-1:0]    reqAddr,
   input  logic [NUM_CACHES*IOSTATE_W-1:0] cRw,
   input  logic [NUM_CACHES*ADDR_W-1:0]    cAddr,
   input  logic [NUM_CACHES*WORD_W-1:0]    cData,
   output logic [NUM_CACHES-1:0]           allowRead,
   output logic [NUM_CACHES-1:0]           snpRm,
   output logic [NUM_CACHES-1:0]           snpWm,
   output logic [NUM_CACHES-1:0]           snpInv,
   output logic [ADDR_W-1:0]               snpAddr,
   output logic [NUM_CACHES-1:0]           cReadEn,
   output logic [NUM_CACHES-1:0]           cWriteDone,
   output logic [WORD_W-1:0]               cDataOut,
   output logic [IOSTATE_W-1:0]            mRw,
   output logic [ADDR_W-1:0]               mAddr,
   output logic [WORD_W-1:0]               mData,
   input  logic [WORD_W-1:0]               mDataIn,
   input  logic                            mReadEn,
   input  logic                            mWriteDone,
   output logic [IDX_W-1:0]                owner,
   output logic                            busy,
   output logic                            err
);

   arb_state_t state, state_n;

   logic [IDX_W-1:0]      rr_ptr, rr_ptr_n;
   logic [IDX_W-1:0]      owner_n;
   logic [IDX_W-1:0]      wb_idx, wb_idx_n;
   logic                  msg_rm, msg_wm, msg_inv;
   logic                  msg_rm_n, msg_wm_n, msg_inv_n;
   logic [TMO_W-1:0]      tmo, tmo_n;
   logic                  err_n;

   logic [NUM_CACHES-1:0] allow_n, snp_rm_n, snp_wm_n, snp_inv_n;
   logic [NUM_CACHES-1:0] read_en_n, write_done_n;
   logic [ADDR_W-1:0]     snp_addr_n, m_addr_n;
   logic [WORD_W-1:0]     data_out_n, m_data_n;
   logic [IOSTATE_W-1:0]  m_rw_n;
   logic [IDX_W-1:0]      mem_src;
   logic                  wb_found;
   logic                  tmo_hit;
   logic                  tmo_restart;

   logic [NUM_CACHES-1:0] pick_grant;
   logic [IDX_W-1:0]      pick_idx;
   logic                  pick_valid;

   snoop_bus_arbiter_rr_picker #(
      .NUM_CACHES (NUM_CACHES)
   ) u_picker (
      .req   (reqMsg),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign tmo_hit = (tmo == TMO_W'(TIMEOUT - 1));

   always_comb begin
      state_n      = state;
      owner_n      = owner;
      rr_ptr_n     = rr_ptr;
      wb_idx_n     = wb_idx;
      msg_rm_n     = msg_rm;
      msg_wm_n     = msg_wm;
      msg_inv_n    = msg_inv;
      err_n        = err;
      snp_rm_n     = '0;
      snp_wm_n     = '0;
      snp_inv_n    = '0;
      snp_addr_n   = snpAddr;
      read_en_n    = '0;
      write_done_n = '0;
      data_out_n   = '0;
      wb_found     = 1'b0;
      tmo_restart  = 1'b0;

      case (state)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_n    = ARB_BCAST;
               owner_n    = pick_idx;
               msg_rm_n   = reqRm[pick_idx];
               msg_wm_n   = reqWm[pick_idx];
               msg_inv_n  = reqInv[pick_idx];
               // Snoop strobes are registered so they line up with BCAST.
               snp_rm_n   = {NUM_CACHES{reqRm[pick_idx]}}  & ~pick_grant;
               snp_wm_n   = {NUM_CACHES{reqWm[pick_idx]}}  & ~pick_grant;
               snp_inv_n  = {NUM_CACHES{reqInv[pick_idx]}} & ~pick_grant;
               snp_addr_n = reqAddr[pick_idx*ADDR_W +: ADDR_W];
            end
         end

         ARB_BCAST: begin
            state_n = inv_only(msg_rm, msg_wm, msg_inv) ? ARB_DONE : ARB_SNOOPWIN;
         end

         ARB_SNOOPWIN: begin
            for (int j = 0; j < NUM_CACHES; j++) begin
               if (!wb_found && (IDX_W'(j) != owner) &&
                   (cRw[j*IOSTATE_W +: IOSTATE_W] == IO_WT) &&
                   (cAddr[j*ADDR_W +: ADDR_W] == snpAddr)) begin
                  wb_found = 1'b1;
                  wb_idx_n = IDX_W'(j);
               end
            end
            state_n = wb_found ? ARB_WB : ARB_OWNER;
         end

         ARB_WB: begin
            if (mWriteDone) begin
               write_done_n[wb_idx] = 1'b1;
               state_n              = ARB_OWNER;
            end else if (tmo_hit) begin
               err_n   = 1'b1;
               state_n = ARB_DONE;
            end
         end

         ARB_OWNER: begin
            if (mReadEn) begin
               read_en_n[owner] = 1'b1;
               data_out_n       = mDataIn;
               state_n          = ARB_DONE;
            end else if (mWriteDone) begin
               // The owner's own write-back finished; its read gets a fresh window.
               write_done_n[owner] = 1'b1;
               tmo_restart         = 1'b1;
            end else if (tmo_hit) begin
               err_n   = 1'b1;
               state_n = ARB_DONE;
            end
         end

         ARB_DONE: begin
            rr_ptr_n = (owner == IDX_W'(NUM_CACHES - 1)) ? '0 : owner + 1'b1;
            state_n  = ARB_IDLE;
         end

         default: begin
            state_n = ARB_IDLE;
         end
      endcase

      // Timeout window: cleared on every state entry, counts only while waiting on memory.
      if (state_n != state || tmo_restart)
         tmo_n = '0;
      else if (state == ARB_WB || state == ARB_OWNER)
         tmo_n = tmo + 1'b1;
      else
         tmo_n = tmo;

      // Memory port follows whichever cache the next state serves.
      mem_src = (state_n == ARB_WB) ? wb_idx_n : owner_n;
      if (state_n == ARB_WB || state_n == ARB_OWNER) begin
         m_rw_n   = cRw[mem_src*IOSTATE_W +: IOSTATE_W];
         m_addr_n = cAddr[mem_src*ADDR_W +: ADDR_W];
         m_data_n = cData[mem_src*WORD_W +: WORD_W];
      end else begin
         m_rw_n   = IO_IDEL;
         m_addr_n = '0;
         m_data_n = '0;
      end

      allow_n = '0;
      if (state_n == ARB_IDLE || state_n == ARB_DONE)
         allow_n = '1;
      else
         allow_n[owner_n] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ARB_IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         wb_idx     <= '0;
         msg_rm     <= 1'b0;
         msg_wm     <= 1'b0;
         msg_inv    <= 1'b0;
         tmo        <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
         allowRead  <= '1;
         snpRm      <= '0;
         snpWm      <= '0;
         snpInv     <= '0;
         snpAddr    <= '0;
         cReadEn    <= '0;
         cWriteDone <= '0;
         cDataOut   <= '0;
         mRw        <= IO_IDEL;
         mAddr      <= '0;
         mData      <= '0;
      end else begin
         state      <= state_n;
         rr_ptr     <= rr_ptr_n;
         owner      <= owner_n;
         wb_idx     <= wb_idx_n;
         msg_rm     <= msg_rm_n;
         msg_wm     <= msg_wm_n;
         msg_inv    <= msg_inv_n;
         tmo        <= tmo_n;
         err        <= err_n;
         busy       <= (state_n != ARB_IDLE);
         allowRead  <= allow_n;
         snpRm      <= snp_rm_n;
         snpWm      <= snp_wm_n;
         snpInv     <= snp_inv_n;
         snpAddr    <= snp_addr_n;
         cReadEn    <= read_en_n;
         cWriteDone <= write_done_n;
         cDataOut   <= data_out_n;
         mRw        <= m_rw_n;
         mAddr      <= m_addr_n;
         mData      <= m_data_n;
      end
   end

endmodule
